// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scanner: per-frame input snapshot,
// leading-zero suppression and a programmable all-dark gap between digits.
module seg7_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  dig_en,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned CntW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CntW-1:0] BlankLoad =
      (BLANK_CYCLES > 0) ? CntW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDrive
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] blank_cnt_q, blank_cnt_d;

  logic [15:0] snap_val_q, snap_val_d;
  logic [3:0]  snap_dp_q, snap_dp_d;
  logic [3:0]  snap_en_q, snap_en_d;
  logic        snap_lz_q, snap_lz_d;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       frame_start_q, frame_start_d;

  logic       wrap;
  logic [3:0] sup;
  logic [3:0] nib;
  logic       dark;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Scan sequencing and frame snapshot.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    blank_cnt_d   = blank_cnt_q;
    snap_val_d    = snap_val_q;
    snap_dp_d     = snap_dp_q;
    snap_en_d     = snap_en_q;
    snap_lz_d     = snap_lz_q;
    frame_start_d = 1'b0;
    wrap          = tick && (idx_q == 2'd3);

    if (tick) begin
      idx_d = idx_q + 2'd1;
      if (BLANK_CYCLES > 0) begin
        state_d     = StBlank;
        blank_cnt_d = BlankLoad;
      end else begin
        state_d = StDrive;
      end
      if (wrap) begin
        snap_val_d    = value;
        snap_dp_d     = dp_mask;
        snap_en_d     = dig_en;
        snap_lz_d     = lz_en;
        frame_start_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StBlank: begin
          if (blank_cnt_q == '0) begin
            state_d = StDrive;
          end else begin
            blank_cnt_d = blank_cnt_q - CntW'(1);
          end
        end
        StDrive: state_d = StDrive;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output pins are computed from the next state so the digit appears on the
  // same edge the FSM enters DRIVE; a tick edge always goes dark.
  always_comb begin
    sup[0] = 1'b0;
    sup[3] = (snap_val_q[15:12] == 4'h0);
    sup[2] = sup[3] && (snap_val_q[11:8] == 4'h0);
    sup[1] = sup[2] && (snap_val_q[7:4] == 4'h0);
    nib    = snap_val_q[{idx_q, 2'b00} +: 4];
    dark   = !snap_en_q[idx_q] || (snap_lz_q && sup[idx_q]);

    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!tick && (state_d == StDrive) && !dark) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(nib);
      dp_d  = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= 2'd3;
      blank_cnt_q   <= '0;
      snap_val_q    <= '0;
      snap_dp_q     <= '0;
      snap_en_q     <= '0;
      snap_lz_q     <= 1'b0;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      blank_cnt_q   <= blank_cnt_d;
      snap_val_q    <= snap_val_d;
      snap_dp_q     <= snap_dp_d;
      snap_en_q     <= snap_en_d;
      snap_lz_q     <= snap_lz_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule
